// File: rtl/exp_pulse_gen_if.sv
// AXI-Stream style sample channel carrying the generated pulse.
// No tready: the source never stalls.
interface exp_pulse_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;

  modport master (output tdata, tvalid);
  modport slave  (input  tdata, tvalid);
endinterface

// File: rtl/exp_pulse_gen.sv
// Exponential-pulse source: single-cycle decay recurrence with a termination
// guard, reload or pile-up on trigger, and an internal periodic auto-trigger.
module exp_pulse_gen #(
  parameter int DATA_WIDTH   = 16,
  parameter int AMP_WIDTH    = 14,
  parameter int FRAC_BITS    = 14,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AMP_WIDTH-1:0]    sig_amp,
  input  logic [FRAC_BITS-1:0]    decay_factor,
  input  logic                    round_en,
  input  logic                    pileup_en,
  input  logic                    auto_en,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    trigger,
  exp_pulse_gen_if.master         m_axis,
  output logic                    busy,
  output logic                    sat_flag,
  output logic [15:0]             trig_count
);
  localparam int PW = AMP_WIDTH + FRAC_BITS + 1;
  localparam logic [PW-1:0] ROUND_HALF = PW'(1) << (FRAC_BITS - 1);

  logic [AMP_WIDTH-1:0]    r_x;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_sat;
  logic [15:0]             r_tc;
  logic                    r_tvalid;

  logic [PW-1:0]           w_p;
  logic [AMP_WIDTH:0]      w_d;
  logic [AMP_WIDTH-1:0]    w_dg;
  logic [AMP_WIDTH:0]      w_sum;
  logic                    w_en;
  logic                    w_tick;
  logic                    w_tacc;
  logic                    w_cnt_clr;

  // Full-precision product; one spare bit keeps the rounding add from wrapping.
  assign w_p  = PW'(r_x) * PW'(decay_factor) + (round_en ? ROUND_HALF : '0);
  assign w_d  = w_p[FRAC_BITS +: AMP_WIDTH+1];

  // A nonzero state must strictly fall, else round-up could pin it forever.
  assign w_dg = ((r_x != '0) && (w_d >= {1'b0, r_x})) ? (r_x - AMP_WIDTH'(1))
                                                      : w_d[AMP_WIDTH-1:0];
  assign w_sum = {1'b0, w_dg} + {1'b0, sig_amp};

  assign w_en      = auto_en && (period != '0);
  assign w_tick    = w_en && (r_cnt == period - PERIOD_WIDTH'(1));
  // Covers the wrap point and an out-of-range count after a period shrink.
  assign w_cnt_clr = !w_en || (r_cnt >= period - PERIOD_WIDTH'(1));
  assign w_tacc    = trigger || w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_tc     <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= 1'b1;
      r_cnt    <= w_cnt_clr ? '0 : r_cnt + PERIOD_WIDTH'(1);
      if (w_tacc) begin
        r_tc <= r_tc + 16'd1;
        if (!pileup_en) begin
          r_x <= sig_amp;
        end else if (w_sum[AMP_WIDTH]) begin
          r_x   <= '1;
          r_sat <= 1'b1;
        end else begin
          r_x <= w_sum[AMP_WIDTH-1:0];
        end
      end else if (r_x != '0) begin
        r_x <= w_dg;
      end
    end
  end

  assign m_axis.tdata  = {{(DATA_WIDTH-AMP_WIDTH){1'b0}}, r_x};
  assign m_axis.tvalid = r_tvalid;
  assign busy          = (r_x != '0);
  assign sat_flag      = r_sat;
  assign trig_count    = r_tc;
endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed and randomized checks of exp_pulse_gen against an integer
// reference model that is stepped once per clock.
module tb_exp_pulse_gen;
  localparam int DW = 16, AW = 14, FB = 14, PWID = 32;
  localparam longint AMAX = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   sig_amp = '0;
  logic [FB-1:0]   decay_factor = '0;
  logic            round_en = 1'b0;
  logic            pileup_en = 1'b0;
  logic            auto_en = 1'b0;
  logic [PWID-1:0] period = '0;
  logic            trigger = 1'b0;
  logic            busy, sat_flag;
  logic [15:0]     trig_count;

  exp_pulse_gen_if #(.DATA_WIDTH(DW)) axis ();

  exp_pulse_gen #(.DATA_WIDTH(DW), .AMP_WIDTH(AW), .FRAC_BITS(FB), .PERIOD_WIDTH(PWID)) dut (
    .clk(clk), .rst(rst), .sig_amp(sig_amp), .decay_factor(decay_factor),
    .round_en(round_en), .pileup_en(pileup_en), .auto_en(auto_en),
    .period(period), .trigger(trigger), .m_axis(axis),
    .busy(busy), .sat_flag(sat_flag), .trig_count(trig_count));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: pulse height, cycles since last auto tick, trigger tally.
  longint m_x = 0, m_cnt = 0;
  int     m_tc = 0;
  bit     m_sat = 0, m_vld = 0;

  task automatic model_step();
    longint per, p, d, s;
    bit en, tick, tacc;
    per  = longint'(period);
    en   = auto_en && per != 0;
    tick = en && (m_cnt == per - 1);
    tacc = trigger || tick;
    p = m_x * longint'(decay_factor) + (round_en ? (64'sd1 << (FB - 1)) : 0);
    d = p / (64'sd1 << FB);
    if (m_x != 0 && d >= m_x) d = m_x - 1;
    if (rst) begin
      m_x = 0; m_cnt = 0; m_sat = 0; m_tc = 0; m_vld = 0;
    end else begin
      m_vld = 1;
      if (tacc) begin
        m_tc = (m_tc + 1) % 65536;
        if (!pileup_en) m_x = sig_amp;
        else begin
          s = d + longint'(sig_amp);
          if (s > AMAX) begin m_x = AMAX; m_sat = 1; end
          else m_x = s;
        end
      end else if (m_x != 0) m_x = d;
      if (!en || m_cnt + 1 >= per) m_cnt = 0;
      else m_cnt = m_cnt + 1;
    end
  endtask

  bit cmp_en = 1;

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    if (cmp_en) begin
      chk("tdata", axis.tdata, m_x);
      chk("tvalid", axis.tvalid, m_vld);
      chk("busy", busy, m_x != 0);
      chk("sat", sat_flag, m_sat);
      chk("trig_count", trig_count, m_tc);
    end
  endtask

  task automatic do_rst();
    rst = 1; trigger = 0; auto_en = 0; pileup_en = 0; round_en = 0;
    cyc();
    rst = 0;
  endtask

  initial begin
    // Reset state
    do_rst();
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_tc", trig_count, 0);
    cyc();
    chk("tvalid_up", axis.tvalid, 1);

    // Reload and halve
    sig_amp = 8000; decay_factor = 8192; trigger = 1;
    cyc();
    chk("halve_peak", axis.tdata, 8000);
    trigger = 0;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      chk("halve_seq", axis.tdata, 8000 >> i);
    end
    chk("halve_busy_low", busy, 0);

    // Guard forces strict decrease under round-up
    sig_amp = 10; decay_factor = 16383; round_en = 1; trigger = 1;
    cyc();
    trigger = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("guard_seq", axis.tdata, 10 - i);
    end
    round_en = 0;

    // Pile-up saturation
    do_rst();
    pileup_en = 1; sig_amp = 12000; decay_factor = 16000; trigger = 1;
    cyc();
    chk("pile_first", axis.tdata, 12000);
    cyc();
    chk("pile_sat_val", axis.tdata, 16383);
    chk("pile_sat_flag", sat_flag, 1);
    trigger = 0;
    repeat (6) cyc();
    chk("pile_sat_sticky", sat_flag, 1);
    pileup_en = 0;

    // Auto-trigger: period 5 over 50 cycles
    do_rst();
    sig_amp = 1000; decay_factor = 8192; auto_en = 1; period = 5;
    repeat (50) cyc();
    chk("auto_count", trig_count, 10);
    chk("auto_reload", axis.tdata, 1000);
    repeat (4) cyc();
    trigger = 1;
    cyc();
    chk("auto_coincide", trig_count, 11);
    trigger = 0; auto_en = 0;

    // Reset mid-pulse with a simultaneous trigger
    do_rst();
    sig_amp = 3000; decay_factor = 16383; trigger = 1;
    cyc();
    chk("mid_peak", axis.tdata, 3000);
    rst = 1;
    cyc();
    chk("mid_rst_x", axis.tdata, 0);
    chk("mid_rst_vld", axis.tvalid, 0);
    chk("mid_rst_tc", trig_count, 0);
    rst = 0; trigger = 0;
    cyc();
    chk("mid_vld_back", axis.tvalid, 1);

    // Zero decay factor collapses in one step
    sig_amp = 500; decay_factor = 0; trigger = 1;
    cyc();
    chk("df0_peak", axis.tdata, 500);
    trigger = 0;
    cyc();
    chk("df0_zero", axis.tdata, 0);

    // Counter wrap after 65537 triggers
    do_rst();
    cmp_en = 0; trigger = 1;
    repeat (65537) cyc();
    cmp_en = 1; trigger = 0;
    chk("tc_wrap", trig_count, 1);
    chk("tc_wrap_model", trig_count, m_tc);

    // Randomized traffic, including period changes while counting
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      trigger      = ($urandom_range(0, 9) == 0);
      sig_amp      = AW'($urandom_range(0, 16383));
      decay_factor = FB'($urandom_range(0, 16383));
      round_en     = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) pileup_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) auto_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 23) == 0) period = PWID'($urandom_range(0, 9));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
